mem_port_arbiter: RTL and testbench

//  Shares one single-port, multi-cycle SRAM between instruction fetch (IF, read-only) and the MEM stage (read/write).

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_port_arbiter_register.sv | 19 +
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the IF/MEM SRAM port arbiter
package mem_port_arbiter_pkg;

   localparam int ADDR_LEN_DEF      = 32;
   localparam int DATA_LEN_DEF      = 32;
   localparam int SRAM_ADDR_LEN_DEF = 16;
   localparam int SRAM_WAIT_DEF     = 2;
   localparam int WAIT_CNT_LEN      = 4;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_MEM = 1'b1
   } owner_t;

   // Wait-state count loaded on grant; values above the counter range saturate.
   function automatic logic [WAIT_CNT_LEN-1:0] wait_load(input int sram_wait);
      if (sram_wait > 15)
         return 4'd15;
      else if (sram_wait < 0)
         return 4'd0;
      else
         return WAIT_CNT_LEN'(sram_wait);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_register.sv
// rtl/mem_port_arbiter_register.sv - enabled capture register with synchronous clear
module mem_port_arbiter_register #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises IF and MEM accesses onto one multi-cycle SRAM port
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_LEN      = ADDR_LEN_DEF,
   parameter int DATA_LEN      = DATA_LEN_DEF,
   parameter int SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF,
   parameter int SRAM_WAIT     = SRAM_WAIT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_req,
   input  logic [ADDR_LEN-1:0]      if_addr,
   output logic                     if_ready,
   output logic [DATA_LEN-1:0]      if_rdata,
   input  logic                     mem_req,
   input  logic                     mem_we,
   input  logic [ADDR_LEN-1:0]      mem_addr,
   input  logic [DATA_LEN-1:0]      mem_wdata,
   output logic                     mem_ready,
   output logic [DATA_LEN-1:0]      mem_rdata,
   output logic                     if_stall,
   output logic                     mem_stall,
   output logic                     sram_en,
   output logic                     sram_we,
   output logic [SRAM_ADDR_LEN-1:0] sram_addr,
   output logic [DATA_LEN-1:0]      sram_wdata,
   input  logic [DATA_LEN-1:0]      sram_rdata
);

   localparam logic [WAIT_CNT_LEN-1:0] WAIT_INIT = wait_load(SRAM_WAIT);

   arb_state_t                state;
   arb_state_t                state_next;
   owner_t                    owner;
   logic [WAIT_CNT_LEN-1:0]   wait_cnt;
   logic [SRAM_ADDR_LEN-1:0]  addr_q;
   logic                      we_q;
   logic [DATA_LEN-1:0]       wdata_q;
   logic                      grant;
   logic                      capture;
   logic                      if_capture;
   logic                      mem_capture;
   logic                      unused_addr_bits;

   // Byte-offset and high address bits never reach the SRAM.
   assign unused_addr_bits = ^{if_addr, mem_addr};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         owner    <= OWNER_IF;
         wait_cnt <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
      end else begin
         state <= state_next;
         if (grant) begin
            // MEM wins ties: it belongs to the older instruction in the pipeline.
            if (mem_req) begin
               owner   <= OWNER_MEM;
               addr_q  <= mem_addr[SRAM_ADDR_LEN+1:2];
               we_q    <= mem_we;
               wdata_q <= mem_wdata;
            end else begin
               owner   <= OWNER_IF;
               addr_q  <= if_addr[SRAM_ADDR_LEN+1:2];
               we_q    <= 1'b0;
               wdata_q <= '0;
            end
            wait_cnt <= WAIT_INIT;
         end else if (state == ARB_ACCESS && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      grant      = 1'b0;
      capture    = 1'b0;
      sram_en    = 1'b0;
      if_ready   = 1'b0;
      mem_ready  = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (mem_req || if_req) begin
               grant      = 1'b1;
               state_next = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            sram_en = 1'b1;
            if (wait_cnt == '0) begin
               capture    = 1'b1;
               state_next = ARB_DONE;
            end
         end
         ARB_DONE: begin
            if_ready   = (owner == OWNER_IF);
            mem_ready  = (owner == OWNER_MEM);
            state_next = ARB_IDLE;
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   assign sram_we    = sram_en && we_q && (owner == OWNER_MEM);
   assign sram_addr  = addr_q;
   assign sram_wdata = wdata_q;

   // Stores leave the load-data register untouched.
   assign if_capture  = capture && (owner == OWNER_IF);
   assign mem_capture = capture && (owner == OWNER_MEM) && !we_q;

   mem_port_arbiter_register #(.WIDTH(DATA_LEN)) u_if_rdata (
      .clk (clk),
      .rst (rst),
      .en  (if_capture),
      .d   (sram_rdata),
      .q   (if_rdata)
   );

   mem_port_arbiter_register #(.WIDTH(DATA_LEN)) u_mem_rdata (
      .clk (clk),
      .rst (rst),
      .en  (mem_capture),
      .d   (sram_rdata),
      .q   (mem_rdata)
   );

   assign if_stall  = if_req && !if_ready;
   assign mem_stall = mem_req && !mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (SRAM_WAIT=2 and SRAM_WAIT=0)
module tb_mem_port_arbiter;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic        if_req, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic        if_ready, mem_ready, if_stall, mem_stall, sram_en, sram_we;
   logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
   logic [15:0] sram_addr;

   logic        if_req_b, mem_req_b, mem_we_b;
   logic [31:0] if_addr_b, mem_addr_b, mem_wdata_b;
   logic        if_ready_b, mem_ready_b, if_stall_b, mem_stall_b, sram_en_b, sram_we_b;
   logic [31:0] if_rdata_b, mem_rdata_b, sram_wdata_b, sram_rdata_b;
   logic [15:0] sram_addr_b;

   logic [31:0] sram_a [0:65535];
   logic [31:0] sram_b [0:65535];
   logic [31:0] model_mem [0:1023];
   logic [31:0] exp_if_rd, exp_mem_rd;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   assign sram_rdata   = sram_a[sram_addr];
   assign sram_rdata_b = sram_b[sram_addr_b];
   always @(posedge clk) if (sram_en && sram_we) sram_a[sram_addr] <= sram_wdata;
   always @(posedge clk) if (sram_en_b && sram_we_b) sram_b[sram_addr_b] <= sram_wdata_b;

   mem_port_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .SRAM_ADDR_LEN(16), .SRAM_WAIT(W)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .if_stall(if_stall), .mem_stall(mem_stall),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   mem_port_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .SRAM_ADDR_LEN(16), .SRAM_WAIT(0)) dut_b (
      .clk(clk), .rst(rst),
      .if_req(if_req_b), .if_addr(if_addr_b), .if_ready(if_ready_b), .if_rdata(if_rdata_b),
      .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_ready(mem_ready_b), .mem_rdata(mem_rdata_b),
      .if_stall(if_stall_b), .mem_stall(mem_stall_b),
      .sram_en(sram_en_b), .sram_we(sram_we_b), .sram_addr(sram_addr_b),
      .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Drives one request on the W=2 instance and observes it until its ready pulse.
   task automatic run_a(input bit is_mem, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                        output int en_n, output int we_n, output int bad, output int other_rdy,
                        output logic stall0);
      logic [15:0] exp_sa;
      exp_sa = addr[17:2];
      lat = 0; en_n = 0; we_n = 0; bad = 0; other_rdy = 0;
      if (is_mem) begin
         mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      #1;
      stall0 = is_mem ? mem_stall : if_stall;
      while (lat < 40) begin
         tick();
         lat++;
         if (sram_en) begin
            en_n++;
            if (sram_addr !== exp_sa) bad++;
         end
         if (sram_we) begin
            we_n++;
            if (sram_wdata !== wdata) bad++;
         end
         if (is_mem ? if_ready : mem_ready) other_rdy++;
         if (is_mem ? mem_ready : if_ready) break;
      end
      rd = is_mem ? mem_rdata : if_rdata;
      mem_req = 1'b0; if_req = 1'b0; mem_we = 1'b0;
      tick();
   endtask

   task automatic check_access(input string tag, input bit is_mem, input bit we,
                               input logic [31:0] addr, input logic [31:0] wdata);
      int lat, en_n, we_n, bad, other_rdy;
      logic [31:0] rd;
      logic stall0;
      bit wr;
      wr = is_mem && we;
      run_a(is_mem, we, addr, wdata, lat, rd, en_n, we_n, bad, other_rdy, stall0);
      chk({tag, ":stall0"}, stall0, 1);
      chk({tag, ":latency"}, lat, W + 2);
      chk({tag, ":en_cycles"}, en_n, W + 1);
      chk({tag, ":we_cycles"}, we_n, wr ? W + 1 : 0);
      chk({tag, ":addr_data"}, bad, 0);
      chk({tag, ":other_ready"}, other_rdy, 0);
      if (wr) begin
         model_mem[addr[11:2]] = wdata;
      end else if (is_mem) begin
         exp_mem_rd = model_mem[addr[11:2]];
      end else begin
         exp_if_rd = model_mem[addr[11:2]];
      end
      chk({tag, ":mem_rdata"}, mem_rdata, exp_mem_rd);
      chk({tag, ":if_rdata"}, if_rdata, exp_if_rd);
      if (!wr) chk({tag, ":rdata"}, rd, model_mem[addr[11:2]]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int mr, ir, stall_n, r1, r2, en_seen;
      logic [15:0] ea1, ea2;
      logic [31:0] d1, d2, rv;

      for (int i = 0; i < 1024; i++) begin
         rv = $urandom;
         sram_a[i] = rv;
         model_mem[i] = rv;
      end
      sram_a[4] = 32'hE3A00005;
      model_mem[4] = 32'hE3A00005;
      sram_b[0] = 32'h11111111;
      sram_b[1] = 32'h22222222;
      exp_if_rd = '0;
      exp_mem_rd = '0;

      rst = 1'b1;
      if_req = 0; mem_req = 0; mem_we = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0;
      if_req_b = 0; mem_req_b = 0; mem_we_b = 0; if_addr_b = 0; mem_addr_b = 0; mem_wdata_b = 0;
      tick(); tick(); tick();
      chk("reset:if_ready", if_ready, 0);
      chk("reset:mem_ready", mem_ready, 0);
      chk("reset:sram_en", sram_en, 0);
      chk("reset:sram_we", sram_we, 0);
      chk("reset:sram_addr", sram_addr, 0);
      chk("reset:sram_wdata", sram_wdata, 0);
      chk("reset:if_rdata", if_rdata, 0);
      chk("reset:mem_rdata", mem_rdata, 0);
      chk("reset:b_sram_en", sram_en_b, 0);
      rst = 1'b0;
      tick();

      check_access("if_read_0x10", 1'b0, 1'b0, 32'h10, 32'h0);
      check_access("mem_write_0x400", 1'b1, 1'b1, 32'h400, 32'hDEADBEEF);
      check_access("mem_read_0x400", 1'b1, 1'b0, 32'h400, 32'h0);
      check_access("mem_write_keeps_rdata", 1'b1, 1'b1, 32'h404, 32'h0BADF00D);
      check_access("if_misaligned_0x13", 1'b0, 1'b0, 32'h13, 32'h0);

      // IF and MEM together: MEM first, IF granted in the IDLE after MEM's DONE.
      if_req = 1'b1; if_addr = 32'h20;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8;
      mr = -1; ir = -1; stall_n = 0;
      #1;
      if (if_stall) stall_n++;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (if_stall) stall_n++;
         if (mem_ready) begin
            mr = c;
            mem_req = 1'b0;
         end
         if (if_ready) begin
            ir = c;
            if_req = 1'b0;
         end
      end
      exp_mem_rd = model_mem[2];
      exp_if_rd = model_mem[8];
      chk("simul:mem_ready_cycle", mr, W + 2);
      chk("simul:if_ready_cycle", ir, 2 * (W + 3) - 1);
      chk("simul:if_stall_cycles", stall_n, 2 * (W + 3) - 1);
      chk("simul:mem_rdata", mem_rdata, exp_mem_rd);
      chk("simul:if_rdata", if_rdata, exp_if_rd);

      // Reset during cycle 2 of a MEM write abandons it without a ready pulse.
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h12345678;
      tick(); tick();
      chk("rst_mid:no_ready_before", mem_ready, 0);
      rst = 1'b1;
      tick();
      chk("rst_mid:sram_en", sram_en, 0);
      chk("rst_mid:sram_we", sram_we, 0);
      chk("rst_mid:sram_addr", sram_addr, 0);
      chk("rst_mid:sram_wdata", sram_wdata, 0);
      chk("rst_mid:mem_ready", mem_ready, 0);
      chk("rst_mid:mem_rdata", mem_rdata, 0);
      chk("rst_mid:if_rdata", if_rdata, 0);
      rst = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0;
      exp_mem_rd = '0;
      exp_if_rd = '0;
      tick();
      check_access("rst_mid:reissue", 1'b1, 1'b1, 32'h500, 32'h12345678);
      check_access("rst_mid:readback", 1'b1, 1'b0, 32'h500, 32'h0);

      for (int i = 0; i < 40; i++) begin
         bit m, w;
         logic [31:0] a, d;
         m = 1'($urandom_range(0, 1));
         w = m && ($urandom_range(0, 1) == 1);
         a = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         check_access($sformatf("rand%0d", i), m, w, a, d);
      end

      // SRAM_WAIT=0 instance: back-to-back IF reads, request held across the ready.
      if_req_b = 1'b1; if_addr_b = 32'h0;
      r1 = -1; r2 = -1; en_seen = 0; ea1 = '1; ea2 = '1; d1 = '0; d2 = '0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (sram_en_b) begin
            if (en_seen == 0) ea1 = sram_addr_b;
            else ea2 = sram_addr_b;
            en_seen++;
         end
         if (if_ready_b) begin
            if (r1 < 0) begin
               r1 = c; d1 = if_rdata_b; if_addr_b = 32'h4;
            end else begin
               r2 = c; d2 = if_rdata_b; if_req_b = 1'b0;
            end
         end
      end
      chk("w0:ready1_cycle", r1, 2);
      chk("w0:ready2_cycle", r2, 5);
      chk("w0:en_cycles", en_seen, 2);
      chk("w0:sram_addr1", ea1, 0);
      chk("w0:sram_addr2", ea2, 1);
      chk("w0:rdata1", d1, 32'h11111111);
      chk("w0:rdata2", d2, 32'h22222222);
      chk("w0:mem_ready_idle", mem_ready_b, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
